instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of decode, wrapped around the combinational instruction ROM (10-bit word address in, 16-bit word out, same cycle).
- Owns the program counter and drives the ROM address.
- Registers fetched words into a small prefetch buffer and presents them to decode on a valid/ready handshake.
- Accepts redirects (branch/jump/return) from downstream. Delay-slot semantics stay with the consumer, which asserts a redirect only after it has accepted the delay-slot word.

Parameters:
- ADDR_WIDTH, 10, instruction word-address width (ROM depth 1024).
- DATA_WIDTH, 16, instruction word width.
- BUFFER_DEPTH, 2, prefetch buffer entries; power of two, ≥2.
- RESET_VECTOR, 10'h000, PC value after reset.

Ports:
- clk  input  1  system clock.
- clk_en  input  1  global clock enable; when low, all state holds.
- sync_rst  input  1  synchronous active-high reset.
- ROM_Address  output  ADDR_WIDTH  address to instruction ROM.
- ROM_Value  input  DATA_WIDTH  ROM word for ROM_Address, same cycle.
- Halt  input  1  suppress new fetches (buffer still drains).
- Redirect_Valid  input  1  flush and restart fetch at Redirect_Target.
- Redirect_Target  input  ADDR_WIDTH  new fetch address.
- Instruction_Valid  output  1  buffer head holds a word.
- Instruction_Ready  input  1  decode accepts head this cycle.
- Instruction_Word  output  DATA_WIDTH  head instruction.
- Instruction_PC  output  ADDR_WIDTH  address of head instruction (decode derives the link value PC+1).

Behaviour:
- Only clk is used. sync_rst has priority over clk_en. All updates occur only when clk_en=1 (or on reset).
- Reset values:
  - PC=RESET_VECTOR, buffer count=0.
  - Instruction_Valid=0; Instruction_Word=0; Instruction_PC=0.
  - ROM_Address=RESET_VECTOR.
- ROM_Address is combinational: Redirect_Valid ? Redirect_Target : PC.
- Pop: occurs when Instruction_Valid & Instruction_Ready.
- Push enable: ~Halt & (count<BUFFER_DEPTH | pop).
  - On push, store {ROM_Address, ROM_Value} at the buffer tail.
  - Next PC = ROM_Address+1, modulo 2^ADDR_WIDTH (3FF→000 wraps silently).
  - Without push, PC holds, except on redirect.
- Redirect cycle:
  - A pop in the same cycle completes normally; that word was consumed.
  - All other buffered entries are discarded.
  - If push is enabled, the target word is pushed as the sole entry and PC=target+1. If Halt=1, the buffer is empty and PC=target.
  - Redirect penalty: the target word is visible at the head the cycle after redirect (0 bubbles beyond the redirect cycle itself).
- Latency: the first word after reset deassertion is valid 1 cycle later (registered). Steady-state throughput is 1 word/cycle with Ready held high.
- Output registers: Instruction_Word and Instruction_PC come from the buffer head registers. There is no combinational path ROM_Value→Instruction_Word.
- Full with no pop: no push; ROM_Address=PC held; nothing is lost or duplicated.
- Empty: Instruction_Valid=0. Instruction_Word/PC hold their last values (don't-care for the consumer).
- Halt=1: buffer drains; Valid drops once empty. PC keeps the next unfetched address. Deasserting Halt resumes fetch from PC.
- clk_en=0: PC, buffer and outputs frozen; handshakes in that cycle are not counted.
- sync_rst mid-operation: buffer cleared and PC=RESET_VECTOR on the next edge, regardless of Redirect/Halt.

Decomposition:
- Package fetch_pkg:
  - FETCH_ADDR_WIDTH, FETCH_DATA_WIDTH, RESET_VECTOR constants.
  - typedef fetch_entry_t {addr, word}.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush and flush-with-push (flush wins over stale contents, simultaneous push lands as the only entry), plus count, full and empty.
- Top level: PC register, address mux, push/pop control.

Test Plan:
1. Reset, Ready=1, ROM loaded with the boot program → cycle 1: Valid=1, PC=000, Word=D18E; cycle 2: PC=001, D590; cycle 3: PC=002, C426; one word per cycle.
2. Ready=0 for 6 cycles after reset → buffer fills to 2 entries (000, 001); ROM_Address holds 002. Release Ready → 000, 001, 002, 003 in order, no gaps or duplicates.
3. Buffer full (PC entries 008, 009), pop of 008 coincident with Redirect_Valid=1, Target=004 → 008 counted consumed; next cycle head PC=004, Word=0606; 009 never presented.
4. Redirect to 3FF → head 3FF (Word 0000), then 000 (D18E): wrap-around verified.
5. Halt=1 with 2 entries buffered, Ready=1 → two words delivered, then Valid=0 and ROM_Address stable. Halt=0 → next word resumes at the following PC. clk_en=0 for 3 cycles → all outputs unchanged.
6. sync_rst asserted mid-stream with full buffer and concurrent Redirect → next cycle Valid=0, ROM_Address=000; following cycle head PC=000, D18E.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, reset vector and buffer entry type for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned    FETCH_ADDR_WIDTH = 10;
  localparam int unsigned    FETCH_DATA_WIDTH = 16;
  localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_VECTOR = 10'h000;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [FETCH_DATA_WIDTH-1:0] word;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Shift-style prefetch FIFO: slot 0 is always the head, so the head outputs are plain registers.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  fetch_entry_t    push_entry,
  output fetch_entry_t    head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  fetch_entry_t        entries_q [DEPTH];
  fetch_entry_t        entries_d [DEPTH];
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       base;

  always_comb begin
    entries_d = entries_q;
    base      = flush ? '0 : count_q - CW'(pop);
    if (pop && !flush) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        entries_d[i] = entries_q[i + 1];
      end
    end
    if (push) begin
      entries_d[base[IDXW-1:0]] = push_entry;
    end
    count_d = base + CW'(push);
    // Head register keeps its last word when the buffer goes empty.
    if (count_d == '0) begin
      entries_d[0] = entries_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head  = entries_q[0];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM and feeds decode through a prefetch buffer.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = fetch_pkg::FETCH_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = fetch_pkg::FETCH_DATA_WIDTH,
  parameter int unsigned BUFFER_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  output logic [ADDR_WIDTH-1:0] ROM_Address,
  input  logic [DATA_WIDTH-1:0] ROM_Value,
  input  logic                  Halt,
  input  logic                  Redirect_Valid,
  input  logic [ADDR_WIDTH-1:0] Redirect_Target,
  output logic                  Instruction_Valid,
  input  logic                  Instruction_Ready,
  output logic [DATA_WIDTH-1:0] Instruction_Word,
  output logic [ADDR_WIDTH-1:0] Instruction_PC
);

  localparam int unsigned CW = $clog2(BUFFER_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   pop, push, flush;
  logic                   buf_full, buf_empty;
  logic [CW-1:0]          buf_count;
  fetch_pkg::fetch_entry_t head, push_entry;

  assign ROM_Address = Redirect_Valid ? Redirect_Target : pc_q;

  always_comb begin
    pop   = clk_en & Instruction_Ready & (buf_count != '0);
    flush = clk_en & Redirect_Valid;
    // A redirect empties the buffer, so the target word always has room unless halted.
    push  = clk_en & ~Halt & (Redirect_Valid | ~buf_full | pop);
    push_entry      = '0;
    push_entry.addr = ROM_Address;
    push_entry.word = ROM_Value;
    pc_d = pc_q;
    if (push) begin
      pc_d = ROM_Address + 1'b1;
    end else if (flush) begin
      pc_d = Redirect_Target;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUFFER_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (sync_rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign Instruction_Valid = ~buf_empty;
  assign Instruction_Word  = head.word;
  assign Instruction_PC    = head.addr;

endmodule
